ex_div: RTL and testbench
=========================

EX_DIV -- requirements
Module: ex_div

Interface
REQ-001 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-002 resetn  input  1  asynchronous, active-low reset.
REQ-003 div_start  input  1  EX-stage instruction is DIV/DIVU, decoded from ID/EX alu_op and held stable while div_stall is high.
REQ-004 div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with div_start.
REQ-005 div_a  input  32  dividend (ID/EX rdata1 after forwarding); sampled with div_start.
REQ-006 div_b  input  32  divisor (ID/EX rdata2 after forwarding); sampled with div_start.
REQ-007 int_flush  input  1  exception/interrupt flush; aborts any operation in progress.
REQ-008 div_stall  output  1  holds ID/EX and upstream stages (drives int_div_stall).
REQ-009 div_done  output  1  one-cycle pulse: div_quot and div_rem are valid for HI/LO write.
REQ-010 div_quot  output  32  quotient (LO write data).
REQ-011 div_rem  output  32  remainder (HI write data).

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-013 IDLE: div_start=1 and int_flush=0 -> capture operands, go BUSY, iteration count = 0; otherwise stay IDLE.
REQ-014 div_stall SHALL be combinationally high in IDLE when div_start=1 and int_flush=0, high throughout BUSY, and low in IDLE otherwise and in DONE.
REQ-015 BUSY SHALL perform one restoring radix-2 iteration per cycle on 32-bit unsigned magnitudes (33-bit partial-remainder subtract) for exactly 32 cycles, then go DONE.
REQ-016 Timing: start seen in cycle 0; BUSY in cycles 1..32; DONE in cycle 33 with div_done=1; div_stall is high in cycles 0..32 (33 stall cycles).
REQ-017 Signed mode: operate on |div_a| and |div_b|; negate quotient when operand signs differ; remainder takes the sign of div_a.
REQ-018 div_quot and div_rem SHALL be registered, sign-corrected on the edge entering DONE, and held stable until the next sign-corrected result is written.
REQ-019 DONE SHALL return to IDLE unconditionally after one cycle and SHALL ignore div_start, so the same instruction does not restart.
REQ-020 Divide by zero SHALL take the normal 33 stall cycles and no exception; unsigned result: quot=0xFFFFFFFF, rem=div_a.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quot=0x80000000, rem=0x00000000, with no exception.
REQ-022 int_flush in BUSY SHALL force IDLE at the next edge; div_done SHALL not assert and div_quot/div_rem SHALL keep their previous values.
REQ-023 int_flush in DONE SHALL not suppress that cycle's div_done pulse; HI/LO commit gating is the EX stage's responsibility.
REQ-024 int_flush with div_start in IDLE SHALL prevent the start and keep div_stall low.

Reset
REQ-025 While resetn=0: state=IDLE, iteration count=0, div_stall=0, div_done=0, div_quot=0, div_rem=0, and all internal operand registers=0.
REQ-026 Reset assertion mid-BUSY SHALL abort immediately; after release the block SHALL accept a fresh div_start with no residue.

Structure
REQ-027 The state encoding (2-bit IDLE/BUSY/DONE) and DIV_ITERS=32 SHALL be placed in the shared CPU constants package.
REQ-028 One combinational sub-module, div_step (one restoring iteration: partial remainder and quotient bit in, updated values out), SHALL be instantiated; sign handling stays in ex_div.

Verification
REQ-029 DIVU 100/7 -> div_stall high cycles 0..32, div_done pulse in cycle 33, quot=0x0000000E, rem=0x00000002.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF.
REQ-031 DIVU 0x12345678/0 -> quot=0xFFFFFFFF, rem=0x12345678 after the normal latency; DIV 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
REQ-032 Flush in cycle 10 of 7/3 -> div_stall low from cycle 11, no div_done, outputs keep their prior values; a new start in cycle 12 then completes correctly.
REQ-033 Back-to-back DIVs (div_start re-asserted in the cycle after DONE) -> second result correct, no restart from the first instruction during DONE.
REQ-034 resetn pulsed low mid-BUSY -> all outputs 0 immediately; subsequent DIVU 9/3 gives quot=3, rem=0.

Source files
------------

// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - shared CPU constants for the EX-stage divider
package ex_div_pkg;

  // Divider sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // One quotient bit per BUSY cycle
  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 5;

  // Two's-complement negate when en is set, pass through otherwise
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring radix-2 divide iteration
module div_step (
  input  logic [31:0] rem_in,
  input  logic        dvd_bit,
  input  logic [31:0] divisor,
  output logic [31:0] rem_out,
  output logic        quot_bit
);

  logic [32:0] shifted;
  logic [32:0] diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract;
  // a borrow in bit 32 means the subtract is discarded (restore)
  always_comb begin
    shifted  = {rem_in, dvd_bit};
    diff     = shifted - {1'b0, divisor};
    quot_bit = ~diff[32];
    rem_out  = diff[32] ? shifted[31:0] : diff[31:0];
  end

endmodule

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle 32-bit signed/unsigned divider for the EX stage
module ex_div
  import ex_div_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_a,
  input  logic [31:0] div_b,
  input  logic        int_flush,
  output logic        div_stall,
  output logic        div_done,
  output logic [31:0] div_quot,
  output logic [31:0] div_rem
);

  div_state_e           state_q;
  div_state_e           state_d;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [31:0]          dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [31:0]          rem_q;   // partial remainder
  logic [31:0]          dsr_q;   // divisor magnitude
  logic                 neg_quot_q;
  logic                 neg_rem_q;

  logic                 start_op;
  logic                 last_iter;
  logic [31:0]          step_rem;
  logic                 step_qbit;
  logic [31:0]          quot_next;

  div_step u_div_step (
    .rem_in   (rem_q),
    .dvd_bit  (dvd_q[31]),
    .divisor  (dsr_q),
    .rem_out  (step_rem),
    .quot_bit (step_qbit)
  );

  assign quot_next = {dvd_q[30:0], step_qbit};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and done; stall is held low while reset is asserted
  always_comb begin
    state_d   = state_q;
    div_stall = 1'b0;
    div_done  = 1'b0;
    start_op  = 1'b0;
    last_iter = 1'b0;
    if (resetn) begin
      case (state_q)
        IDLE: begin
          if (div_start && !int_flush) begin
            start_op  = 1'b1;
            div_stall = 1'b1;
            state_d   = BUSY;
          end
        end
        BUSY: begin
          div_stall = 1'b1;
          if (int_flush) begin
            state_d = IDLE;
          end else if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) begin
            last_iter = 1'b1;
            state_d   = DONE;
          end
        end
        DONE: begin
          // The instruction that started us is still in EX; never restart here
          div_done = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand capture, iteration datapath and sign-corrected result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      dvd_q      <= '0;
      rem_q      <= '0;
      dsr_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_quot   <= '0;
      div_rem    <= '0;
    end else if (start_op) begin
      cnt_q      <= '0;
      dvd_q      <= cond_neg(div_a, div_signed & div_a[31]);
      dsr_q      <= cond_neg(div_b, div_signed & div_b[31]);
      rem_q      <= '0;
      neg_quot_q <= div_signed & (div_a[31] ^ div_b[31]);
      neg_rem_q  <= div_signed & div_a[31];
    end else if (state_q == BUSY && !int_flush) begin
      cnt_q <= cnt_q + 1'b1;
      dvd_q <= quot_next;
      rem_q <= step_rem;
      if (last_iter) begin
        div_quot <= cond_neg(quot_next, neg_quot_q);
        div_rem  <= cond_neg(step_rem, neg_rem_q);
      end
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - self-checking bench for ex_div
module tb_ex_div;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic [31:0] div_a = '0;
  logic [31:0] div_b = '0;
  logic        int_flush = 1'b0;
  logic        div_stall;
  logic        div_done;
  logic [31:0] div_quot;
  logic [31:0] div_rem;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } res_t;

  res_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  ex_div dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .int_flush  (int_flush),
    .div_stall  (div_stall),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t              e;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      e.q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      e.r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else if (s) begin
      e.q = sa / sb;
      e.r = sa % sb;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    div_a      = a;
    div_b      = b;
    div_signed = s;
    div_start  = 1'b1;
    sb_q.push_back(model(a, b, s));
    #1;
    checks++;
    if (div_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_cycle0 got %b want 1", div_stall);
    end
  endtask

  task automatic wait_done(input string name);
    bit   seen;
    int   stall_bad;
    res_t e;
    seen      = 0;
    stall_bad = 0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (div_done === 1'b1) begin
        seen = 1;
        checks++;
        if (cyc != 33) begin
          errors++;
          $display("FAIL %s latency got cycle %0d want 33", name, cyc);
        end
        checks++;
        if (div_stall !== 1'b0) begin
          errors++;
          $display("FAIL %s stall_in_done got %b want 0", name, div_stall);
        end
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard got result with no expected entry", name);
        end else begin
          e = sb_q.pop_front();
          if (div_quot !== e.q) begin
            errors++;
            $display("FAIL %s quot got %h want %h", name, div_quot, e.q);
          end
          checks++;
          if (div_rem !== e.r) begin
            errors++;
            $display("FAIL %s rem got %h want %h", name, div_rem, e.r);
          end
          last_q = e.q;
          last_r = e.r;
        end
      end else if (div_stall !== 1'b1) begin
        stall_bad++;
      end
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL %s stall_busy dropped in %0d cycles want 0", name, stall_bad);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got no div_done want pulse in cycle 33", name);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string name);
    @(negedge clk);
    start_op(a, b, s);
    wait_done(name);
    div_start = 1'b0;
    @(negedge clk);
    checks++;
    if (div_done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_one_cycle got %b want 0", name, div_done);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (div_stall !== 1'b0 || div_done !== 1'b0 || div_quot !== 32'd0 || div_rem !== 32'd0) begin
      errors++;
      $display("FAIL %s outputs got stall=%b done=%b quot=%h rem=%h want all 0",
               name, div_stall, div_done, div_quot, div_rem);
    end
  endtask

  task automatic test_reset;
    resetn    = 1'b0;
    div_start = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    div_start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_zero_outputs("after_reset");
  endtask

  task automatic test_divu_basic;
    run_op(32'd100, 32'd7, 1'b0, "divu_100_7");
  endtask

  task automatic test_signed;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, "div_100_m7");
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, "div_m100_m7");
  endtask

  task automatic test_div_zero;
    run_op(32'h1234_5678, 32'd0, 1'b0, "divu_by_zero");
  endtask

  task automatic test_overflow;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow");
  endtask

  task automatic test_flush;
    logic [31:0] pq;
    logic [31:0] pr;
    pq = last_q;
    pr = last_r;
    @(negedge clk);
    div_a      = 32'd7;
    div_b      = 32'd3;
    div_signed = 1'b0;
    div_start  = 1'b1;
    repeat (10) @(negedge clk);
    int_flush = 1'b1;
    div_start = 1'b0;
    #1;
    checks++;
    if (div_stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_c10_stall got %b want 1", div_stall);
    end
    @(negedge clk);
    int_flush = 1'b0;
    #1;
    checks++;
    if (div_stall !== 1'b0 || div_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_c11 got stall=%b done=%b want 0 0", div_stall, div_done);
    end
    checks++;
    if (div_quot !== pq || div_rem !== pr) begin
      errors++;
      $display("FAIL flush_hold got quot=%h rem=%h want %h %h", div_quot, div_rem, pq, pr);
    end
    @(negedge clk);
    start_op(32'd7, 32'd3, 1'b0);
    wait_done("flush_restart_7_3");
    div_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush_start_idle;
    @(negedge clk);
    div_a     = 32'd5;
    div_b     = 32'd1;
    div_start = 1'b1;
    int_flush = 1'b1;
    #1;
    checks++;
    if (div_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_stall got %b want 0", div_stall);
    end
    @(negedge clk);
    div_start = 1'b0;
    int_flush = 1'b0;
    #1;
    checks++;
    if (div_stall !== 1'b0 || div_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle_nostart got stall=%b done=%b want 0 0", div_stall, div_done);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    start_op(32'd1000, 32'd10, 1'b0);
    wait_done("b2b_first");
    div_a      = 32'hFFFF_FF9C;
    div_b      = 32'd7;
    div_signed = 1'b1;
    sb_q.push_back(model(32'hFFFF_FF9C, 32'd7, 1'b1));
    #1;
    checks++;
    if (div_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_ignores_start stall got %b want 0", div_stall);
    end
    @(negedge clk);
    checks++;
    if (div_stall !== 1'b1 || div_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_cycle0 got stall=%b done=%b want 1 0", div_stall, div_done);
    end
    wait_done("b2b_second");
    div_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy;
    @(negedge clk);
    div_a      = 32'd1000;
    div_b      = 32'd3;
    div_signed = 1'b0;
    div_start  = 1'b1;
    repeat (5) @(negedge clk);
    resetn    = 1'b0;
    div_start = 1'b0;
    #1;
    check_zero_outputs("reset_mid_busy");
    @(negedge clk);
    resetn = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, "divu_9_3_after_reset");
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      s = 1'($urandom_range(0, 1));
      if (b == 32'd0) b = 32'd1;
      run_op(a, b, s, "random");
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush();
    test_flush_start_idle();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
